// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues one ibus request at a time, and buffers
// returned instructions (or misalign markers) in a DEPTH-entry FIFO for decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign,
  output logic        stallf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } entry_t;

  state_t         state, state_nxt;
  logic [63:0]    pc, pc_nxt;
  logic [63:0]    req_addr;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  entry_t         mem [DEPTH];
  entry_t         push_entry;
  logic           full, push, pop, issue;

  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid & out_ready & ~redirect;

  // Next-state, PC update and push decision; redirect overrides everything.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    push       = 1'b0;
    issue      = 1'b0;
    push_entry = '{pc: pc, instr: 32'h0, misalign: 1'b0};
    case (state)
      IDLE: begin
        if (!redirect && !full) begin
          if (pc[1:0] != 2'b00) begin
            push                = 1'b1;
            push_entry.misalign = 1'b1;
            state_nxt           = HALT;
          end else begin
            issue     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (iresp_data_ok) begin
          if (!redirect) begin
            push             = 1'b1;
            push_entry.instr = iresp_data;
            pc_nxt           = pc + 64'd4;
          end
          state_nxt = IDLE;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (iresp_data_ok) state_nxt = IDLE;
      end
      HALT: begin
        if (redirect) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) pc_nxt = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (issue) req_addr <= pc;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push && !redirect && !reset) mem[wr_ptr] <= push_entry;
  end

  assign ireq_valid   = (state == REQ) | (state == DROP);
  assign ireq_addr    = req_addr;
  assign out_valid    = (count != '0);
  assign out_pc       = mem[rd_ptr].pc;
  assign out_instr    = mem[rd_ptr].instr;
  assign out_misalign = out_valid & mem[rd_ptr].misalign;
  assign stallf       = full | ((state == REQ) & ~iresp_data_ok) | (state == DROP);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random ibus latency / decode readiness / redirects,
// checked against a queue-based model of the expected instruction stream.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
  logic        stallf;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_misalign(out_misalign),
    .stallf(stallf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: expected FIFO contents, fetch PC, bus bookkeeping.
  entry_t      q[$];
  logic [63:0] mpc;
  logic [63:0] req_addr;
  logic [63:0] last_new_addr;
  bit          halted, outstanding, dead, force_ok;
  int          lat_cnt, lat_min, lat_max, rdy_pct, new_reqs;
  int          nchk, npass;

  task automatic cycle();
    entry_t e;
    bit     ok_now, pop_now, exp_stall;
    out_ready     = ($urandom_range(99, 0) < rdy_pct);
    ok_now        = force_ok || (outstanding && lat_cnt == 0);
    iresp_data_ok = ok_now;
    iresp_data    = $urandom();
    #1;
    if (!reset) begin
      if (ireq_valid && !outstanding) begin
        nchk++;
        if (halted) $display("FAIL req_while_halted addr=%h", ireq_addr);
        else if (ireq_addr !== mpc) $display("FAIL req_addr got=%h exp=%h", ireq_addr, mpc);
        else npass++;
        outstanding   = 1'b1;
        dead          = 1'b0;
        req_addr      = ireq_addr;
        last_new_addr = ireq_addr;
        lat_cnt       = $urandom_range(lat_max, lat_min);
        new_reqs++;
      end else if (outstanding) begin
        nchk++;
        if (ireq_valid !== 1'b1 || ireq_addr !== req_addr)
          $display("FAIL req_hold valid=%b addr=%h exp_addr=%h", ireq_valid, ireq_addr, req_addr);
        else npass++;
      end
      exp_stall = (q.size() == DEPTH) || (outstanding && (dead || !ok_now));
      nchk++;
      if (stallf !== exp_stall) $display("FAIL stallf got=%b exp=%b", stallf, exp_stall);
      else npass++;
      if (!halted) begin
        nchk++;
        if (out_valid !== (q.size() != 0))
          $display("FAIL out_valid got=%b exp=%b", out_valid, (q.size() != 0));
        else npass++;
      end
      if (q.size() == 0) begin
        nchk++;
        if (out_valid !== 1'b0 || out_misalign !== 1'b0)
          $display("FAIL empty_outputs valid=%b mis=%b", out_valid, out_misalign);
        else npass++;
      end else if (out_valid) begin
        e = q[0];
        nchk++;
        if (out_pc !== e.pc || out_instr !== e.instr || out_misalign !== e.mis)
          $display("FAIL head got=%h/%h/%b exp=%h/%h/%b", out_pc, out_instr, out_misalign,
                   e.pc, e.instr, e.mis);
        else npass++;
      end
      if (q.size() == DEPTH) begin
        nchk++;
        if (ireq_valid !== 1'b0) $display("FAIL full_no_req got=%b exp=0", ireq_valid);
        else npass++;
      end
    end
    pop_now = !reset && out_valid && out_ready && !redirect;
    @(posedge clk);
    if (reset) begin
      q.delete();
      mpc = RESET_PC; halted = 1'b0; outstanding = 1'b0; dead = 1'b0;
    end else if (redirect) begin
      q.delete();
      mpc    = redirect_pc;
      halted = (redirect_pc[1:0] != 2'b00);
      if (halted) begin
        e.pc = redirect_pc; e.instr = 32'h0; e.mis = 1'b1;
        q.push_back(e);
      end
      if (outstanding) begin
        if (ok_now) outstanding = 1'b0;
        else dead = 1'b1;
      end
    end else begin
      if (pop_now) void'(q.pop_front());
      if (outstanding && ok_now) begin
        if (!dead) begin
          e.pc = req_addr; e.instr = iresp_data; e.mis = 1'b0;
          q.push_back(e);
          mpc = mpc + 64'd4;
        end
        outstanding = 1'b0;
        dead        = 1'b0;
      end
    end
    if (outstanding && !ok_now && lat_cnt > 0) lat_cnt--;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    nchk++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0 || out_misalign !== 1'b0 || stallf !== 1'b0)
      $display("FAIL reset_outputs req=%b valid=%b mis=%b stall=%b exp=0000",
               ireq_valid, out_valid, out_misalign, stallf);
    else npass++;
  endtask

  task automatic test_stream();
    int start;
    do_reset();
    start = new_reqs;
    for (int i = 0; i < 40; i++) cycle();
    nchk++;
    if (new_reqs - start < 10) $display("FAIL stream_reqs got=%0d exp>=10", new_reqs - start);
    else npass++;
  endtask

  task automatic test_backpressure();
    int nr;
    do_reset();
    rdy_pct = 0;
    for (int i = 0; i < 30; i++) cycle();
    nchk++;
    if (out_valid !== 1'b1 || stallf !== 1'b1 || ireq_valid !== 1'b0 || out_pc !== RESET_PC)
      $display("FAIL bp_full valid=%b stall=%b req=%b pc=%h exp=1/1/0/%h",
               out_valid, stallf, ireq_valid, out_pc, RESET_PC);
    else npass++;
    rdy_pct = 100;
    nr = new_reqs;
    for (int i = 0; i < 20 && new_reqs == nr; i++) cycle();
    nchk++;
    if (new_reqs == nr || last_new_addr !== 64'h8000_0010)
      $display("FAIL bp_resume got=%h exp=80000010", last_new_addr);
    else npass++;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_redirect_pending();
    int nr;
    do_reset();
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 10 && !outstanding; i++) cycle();
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    cycle();
    redirect = 1'b0;
    lat_cnt  = 2;
    lat_min = 1; lat_max = 1;
    nr = new_reqs;
    for (int i = 0; i < 20 && new_reqs == nr; i++) cycle();
    nchk++;
    if (new_reqs == nr || last_new_addr !== 64'h8000_1000)
      $display("FAIL redir_pending got=%h exp=80001000", last_new_addr);
    else npass++;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_redirect_same();
    int nr;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !(outstanding && lat_cnt == 0); i++) cycle();
    redirect = 1'b1; redirect_pc = 64'h8000_2000;
    cycle();
    redirect = 1'b0;
    nchk++;
    if (out_valid !== 1'b0) $display("FAIL redir_same_empty got=%b exp=0", out_valid);
    else npass++;
    nr = new_reqs;
    for (int i = 0; i < 20 && new_reqs == nr; i++) cycle();
    nchk++;
    if (new_reqs == nr || last_new_addr !== 64'h8000_2000)
      $display("FAIL redir_same_restart got=%h exp=80002000", last_new_addr);
    else npass++;
  endtask

  task automatic test_misalign();
    int nr;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10 && ireq_valid; i++) cycle();
    rdy_pct  = 0;
    redirect = 1'b1; redirect_pc = 64'h8000_0002;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    nchk++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_pc !== 64'h8000_0002 ||
        out_instr !== 32'h0 || ireq_valid !== 1'b0)
      $display("FAIL misalign_entry valid=%b mis=%b pc=%h instr=%h req=%b",
               out_valid, out_misalign, out_pc, out_instr, ireq_valid);
    else npass++;
    rdy_pct = 100;
    nr = new_reqs;
    for (int i = 0; i < 12; i++) cycle();
    nchk++;
    if (new_reqs != nr) $display("FAIL halt_no_fetch got=%0d exp=0", new_reqs - nr);
    else npass++;
    redirect = 1'b1; redirect_pc = 64'h8000_0100;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 20 && new_reqs == nr; i++) cycle();
    nchk++;
    if (new_reqs == nr || last_new_addr !== 64'h8000_0100)
      $display("FAIL halt_resume got=%h exp=80000100", last_new_addr);
    else npass++;
  endtask

  task automatic test_reset_mid_req();
    int nr;
    do_reset();
    rdy_pct = 0; lat_min = 5; lat_max = 5;
    for (int i = 0; i < 10; i++) cycle();
    for (int i = 0; i < 10 && !outstanding; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    nchk++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0 || out_misalign !== 1'b0 || stallf !== 1'b0)
      $display("FAIL midreq_reset req=%b valid=%b mis=%b stall=%b exp=0000",
               ireq_valid, out_valid, out_misalign, stallf);
    else npass++;
    force_ok = 1'b1;
    cycle();
    force_ok = 1'b0;
    nchk++;
    if (out_valid !== 1'b0) $display("FAIL late_ok_ignored got=%b exp=0", out_valid);
    else npass++;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    nr = new_reqs;
    for (int i = 0; i < 10 && new_reqs == nr; i++) cycle();
    nchk++;
    if (new_reqs == nr || last_new_addr !== RESET_PC)
      $display("FAIL midreq_restart got=%h exp=%h", last_new_addr, RESET_PC);
    else npass++;
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4; rdy_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99, 0) < 4) begin
        redirect    = 1'b1;
        redirect_pc = RESET_PC + 64'($urandom_range(255, 0)) * 64'd4 +
                      (($urandom_range(5, 0) == 0) ? 64'd2 : 64'd0);
      end
      if (i % 300 == 150) rdy_pct = 10;
      if (i % 300 == 0)   rdy_pct = 60;
      cycle();
      redirect = 1'b0;
    end
  endtask

  initial begin
    nchk = 0; npass = 0; new_reqs = 0; lat_cnt = 0;
    halted = 1'b0; outstanding = 1'b0; dead = 1'b0; force_ok = 1'b0;
    mpc = RESET_PC; req_addr = RESET_PC; last_new_addr = '0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    iresp_data_ok = 1'b0; iresp_data = '0;
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_pending();
    test_redirect_same();
    test_misalign();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
